random_access_memory_unit: RTL and testbench

//  Word-addressed RAM with an internal memory-address register (MAR), one clock domain.
//  CPU bus-side memory: address arrives on a shared bus; set_address loads the MAR; set writes; enable reads.

---
 rtl/random_access_memory_unit_pkg.sv | 10 +
 rtl/random_access_memory_unit_mar.sv | 22 ++
 rtl/random_access_memory_unit.sv | 49 ++++
 tb/tb_random_access_memory_unit.sv | 131 +++++++++++++
 4 files changed

// File: rtl/random_access_memory_unit_pkg.sv
// Shared constants and word/address types for the bus-side RAM.
package random_access_memory_unit_pkg;

  localparam int SIZE_DEFAULT     = 16;
  localparam int MAR_SIZE_DEFAULT = 8;

  typedef logic [SIZE_DEFAULT-1:0]     word_t;
  typedef logic [MAR_SIZE_DEFAULT-1:0] addr_t;

endpackage

// File: rtl/random_access_memory_unit_mar.sv
// Memory-address register: holds the last bus address loaded by set_address.
module ram_address_register
  import random_access_memory_unit_pkg::*;
#(
  parameter int MAR_SIZE = MAR_SIZE_DEFAULT
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load,
  input  logic [MAR_SIZE-1:0] address,
  output logic [MAR_SIZE-1:0] mar
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mar <= '0;
    end else if (load) begin
      mar <= address;
    end
  end

endmodule

// File: rtl/random_access_memory_unit.sv
// Word-addressed RAM with an internal MAR; reads are combinational and gated by enable.
module random_access_memory_unit
  import random_access_memory_unit_pkg::*;
#(
  parameter int SIZE     = SIZE_DEFAULT,
  parameter int MAR_SIZE = MAR_SIZE_DEFAULT
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [MAR_SIZE-1:0] address,
  input  logic                set_address,
  input  logic                set,
  input  logic                enable,
  input  logic [SIZE-1:0]     data_in,
  output logic [SIZE-1:0]     data_out
);

  localparam int DEPTH = 2 ** MAR_SIZE;

  logic [MAR_SIZE-1:0] mar;
  logic [MAR_SIZE-1:0] ea;
  logic [SIZE-1:0]     mem [DEPTH];

  ram_address_register #(
    .MAR_SIZE(MAR_SIZE)
  ) u_mar (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (set_address),
    .address(address),
    .mar    (mar)
  );

  // A freshly presented bus address bypasses the MAR so load and access share one cycle.
  assign ea = set_address ? address : mar;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (set) begin
      mem[ea] <= data_in;
    end
  end

  assign data_out = enable ? mem[ea] : '0;

endmodule

// File: tb/tb_random_access_memory_unit.sv
// Directed self-checking bench for random_access_memory_unit.
module tb_random_access_memory_unit;
  import random_access_memory_unit_pkg::*;

  logic  clk;
  logic  rst_n;
  addr_t address;
  logic  set_address;
  logic  set;
  logic  enable;
  word_t data_in;
  word_t data_out;

  int total;
  int bad;

  random_access_memory_unit dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .address    (address),
    .set_address(set_address),
    .set        (set),
    .enable     (enable),
    .data_in    (data_in),
    .data_out   (data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string tag, input word_t got, input word_t exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic apply_stimulus(input addr_t a, input logic sa, input logic s,
                                input logic en, input word_t d);
    address     = a;
    set_address = sa;
    set         = s;
    enable      = en;
    data_in     = d;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Single write through the bypass path, then idle the write strobe.
  task automatic write_word(input addr_t a, input word_t d);
    apply_stimulus(a, 1'b1, 1'b1, 1'b0, d);
    tick();
    set = 1'b0;
  endtask

  task automatic read_expect(input string tag, input addr_t a, input word_t exp);
    apply_stimulus(a, 1'b1, 1'b0, 1'b1, '0);
    #1;
    check_output(tag, data_out, exp);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    apply_stimulus(8'd0, 1'b1, 1'b0, 1'b1, '0);
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1 check_output("reset_out", data_out, 16'h0000);
    tick();
    rst_n = 1'b1;

    for (int n = 0; n < 256; n++) begin
      read_expect("reset_sweep", addr_t'(n), 16'h0000);
    end

    for (int n = 0; n < 5; n++) begin
      write_word(addr_t'(n), 16'hAAAA);
      enable = 1'b1;
      #1 check_output("wr_rd_low", data_out, 16'hAAAA);
    end
    write_word(8'd200, 16'hC3C3);
    write_word(8'd255, 16'h8001);
    read_expect("wr_rd_200", 8'd200, 16'hC3C3);
    read_expect("neighbour_201", 8'd201, 16'h0000);
    read_expect("wr_rd_255", 8'd255, 16'h8001);
    read_expect("untouched_5", 8'd5, 16'h0000);

    write_word(8'd5, 16'h1234);
    apply_stimulus(8'd9, 1'b0, 1'b0, 1'b1, '0);
    #1 check_output("mar_hold", data_out, 16'h1234);
    set_address = 1'b1;
    #1 check_output("bypass_9", data_out, 16'h0000);

    write_word(8'd10, 16'hFFFF);
    apply_stimulus(8'd10, 1'b1, 1'b0, 1'b0, '0);
    #1 check_output("enable_low", data_out, 16'h0000);
    enable = 1'b1;
    #1 check_output("enable_high", data_out, 16'hFFFF);

    apply_stimulus(8'd7, 1'b1, 1'b1, 1'b1, 16'h5A5A);
    #1 check_output("rmw_before", data_out, 16'h0000);
    tick();
    check_output("rmw_after", data_out, 16'h5A5A);

    // MAR now holds 7; reset must clear both the array and the MAR without a clock.
    apply_stimulus(8'd99, 1'b0, 1'b0, 1'b1, '0);
    #1 check_output("pre_reset_mar", data_out, 16'h5A5A);
    rst_n = 1'b0;
    #1 check_output("async_reset_out", data_out, 16'h0000);
    apply_stimulus(8'd7, 1'b1, 1'b1, 1'b1, 16'hDEAD);
    tick();
    check_output("reset_mem7", data_out, 16'h0000);
    address = 8'd10;
    #1 check_output("reset_mem10", data_out, 16'h0000);
    set = 1'b0;
    rst_n = 1'b1;
    apply_stimulus(8'd33, 1'b0, 1'b1, 1'b0, 16'h0BEE);
    tick();
    set = 1'b0;
    read_expect("reset_mar_zero", 8'd0, 16'h0BEE);
    read_expect("no_stray_33", 8'd33, 16'h0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
